carr_update_sched: RTL and testbench

CARR_UPDATE_SCHED -- requirements
Module: carr_update_sched

---
 rtl/carr_update_sched_pkg.sv | 27 ++
 rtl/carr_update_sched_ch.sv | 95 +++++++++
 rtl/carr_update_sched.sv | 123 ++++++++++++
 tb/tb_carr_update_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carr_update_sched_pkg.sv
// PKG_pwm: shared PWM carrier types for the carrier update scheduler.
// Holds count modes, on/off enable, scheduler states and `PWMCOUNT_WIDTH.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

    typedef enum logic [1:0] {
        NO_COUNT     = 2'd0,
        COUNT_UP     = 2'd1,
        COUNT_DOWN   = 2'd2,
        COUNT_UPDOWN = 2'd3
    } _count_mode;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } _sched_state;

endpackage

// File: rtl/carr_update_sched_ch.sv
// carr_shadow_ch: one carrier channel - shadow, active, pending, event detect.
// Ports: clk/reset, scheduler state + go_run/to_idle strobes, wr_en + cfg_*,
//   carrier feedback; outputs period/init_carr/mode/onoff (registered),
//   pending flag and upd_done pulse.
// CARR_UPD_PEAK_EN adds a carrier==period event alongside the zero point.
module carr_shadow_ch
    import PKG_pwm::*;
#(
    parameter int CW = `PWMCOUNT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  _sched_state   state,
    input  logic          go_run,
    input  logic          to_idle,
    input  logic          wr_en,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_init,
    input  _count_mode    cfg_mode,
    input  logic [CW-1:0] carrier,
    output logic [CW-1:0] period,
    output logic [CW-1:0] init_carr,
    output _count_mode    mode,
    output _pwm_onoff     onoff,
    output logic          pending,
    output logic          upd_done
);

    logic [CW-1:0] sh_period;
    logic [CW-1:0] sh_init;
    _count_mode    sh_mode;
    logic          evt;

    // A stopped channel (period 0 or NO_COUNT) sits permanently at zero.
`ifdef CARR_UPD_PEAK_EN
    assign evt = (carrier == '0) || (carrier == period) ||
                 (period == '0) || (mode == NO_COUNT);
`else
    assign evt = (carrier == '0) ||
                 (period == '0) || (mode == NO_COUNT);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period    <= '0;
            init_carr <= '0;
            mode      <= NO_COUNT;
            onoff     <= PWM_OFF;
            pending   <= 1'b0;
            upd_done  <= 1'b0;
            sh_period <= '0;
            sh_init   <= '0;
            sh_mode   <= NO_COUNT;
        end else begin
            upd_done <= 1'b0;
            case (state)
                IDLE: begin
                    pending <= 1'b0;
                    if (wr_en) begin
                        period    <= cfg_period;
                        init_carr <= cfg_init;
                        mode      <= cfg_mode;
                        upd_done  <= 1'b1;
                    end
                    if (go_run) onoff <= PWM_ON;
                end
                RUN: begin
                    // wr_en needs !pending, so a write never
                    // collides with a transfer in one cycle.
                    if (pending && evt) begin
                        period    <= sh_period;
                        init_carr <= sh_init;
                        mode      <= sh_mode;
                        pending   <= 1'b0;
                        upd_done  <= 1'b1;
                    end else if (wr_en) begin
                        sh_period <= cfg_period;
                        sh_init   <= cfg_init;
                        sh_mode   <= cfg_mode;
                        pending   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (evt) onoff <= PWM_OFF;
                    if (to_idle) pending <= 1'b0;
                end
                default: begin
                    onoff   <= PWM_OFF;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/carr_update_sched.sv
// carr_update_sched: IDLE/RUN/DRAIN scheduler for glitch-free carrier updates.
// Ports: cfg_valid/cfg_ready/cfg_ch/cfg_period/cfg_init/cfg_mode write port,
//   start/stop, carrier_i feedback; period_o, init_carr_o, count_mode_o,
//   pwm_onoff_o, upd_done, busy. Optional macro: CARR_UPD_PEAK_EN.
module carr_update_sched
    import PKG_pwm::*;
#(
    parameter int N_CARR = 8,
    parameter int CW     = `PWMCOUNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(N_CARR)-1:0] cfg_ch,
    input  logic [CW-1:0]             cfg_period,
    input  logic [CW-1:0]             cfg_init,
    input  _count_mode                cfg_mode,
    input  logic                      start,
    input  logic                      stop,
    input  logic [N_CARR*CW-1:0]      carrier_i,
    output logic [N_CARR*CW-1:0]      period_o,
    output logic [N_CARR*CW-1:0]      init_carr_o,
    output _count_mode                count_mode_o [N_CARR],
    output _pwm_onoff                 pwm_onoff_o [N_CARR],
    output logic [N_CARR-1:0]         upd_done,
    output logic                      busy
);

    localparam int CHW = $clog2(N_CARR);

    _sched_state       state;
    logic [N_CARR-1:0] pending;
    logic [N_CARR-1:0] wr_en;
    logic [N_CARR-1:0] ch_off;
    logic              go_run;
    logic              to_idle;
    logic              all_off;
    logic              pend_sel;
    logic              ch_hit;

    assign all_off = &ch_off;
    // stop beats a simultaneous start, even from IDLE
    assign go_run  = (state == IDLE) && start && !stop;
    assign to_idle = (state == DRAIN) && all_off;

    always_comb begin
        pend_sel = 1'b0;
        ch_hit   = 1'b0;
        for (int i = 0; i < N_CARR; i++) begin
            if (cfg_ch == CHW'(i)) begin
                ch_hit   = 1'b1;
                pend_sel = pending[i];
            end
        end
    end

    always_comb begin
        cfg_ready = 1'b0;
        case (state)
            IDLE:    cfg_ready = 1'b1;
            RUN:     cfg_ready = ch_hit && !pend_sel;
            default: cfg_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_run) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) state <= DRAIN;
                end
                DRAIN: begin
                    if (all_off) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_CARR; g++) begin : g_ch
        assign wr_en[g]  = cfg_valid && cfg_ready &&
                           (cfg_ch == CHW'(g));
        assign ch_off[g] = (pwm_onoff_o[g] == PWM_OFF);

        carr_shadow_ch #(
            .CW(CW)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .state     (state),
            .go_run    (go_run),
            .to_idle   (to_idle),
            .wr_en     (wr_en[g]),
            .cfg_period(cfg_period),
            .cfg_init  (cfg_init),
            .cfg_mode  (cfg_mode),
            .carrier   (carrier_i[g*CW +: CW]),
            .period    (period_o[g*CW +: CW]),
            .init_carr (init_carr_o[g*CW +: CW]),
            .mode      (count_mode_o[g]),
            .onoff     (pwm_onoff_o[g]),
            .pending   (pending[g]),
            .upd_done  (upd_done[g])
        );
    end

endmodule

// File: tb/tb_carr_update_sched.sv
// tb_carr_update_sched: directed bench for carr_update_sched.
// Writes push expected transfers to a scoreboard; a monitor pops on upd_done.
module tb_carr_update_sched;
    import PKG_pwm::*;

    localparam int N  = 8;
    localparam int CW = 16;

    typedef struct {
        int            ch;
        logic [CW-1:0] per;
        logic [CW-1:0] ini;
        _count_mode    md;
        int            at;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [2:0]      cfg_ch = '0;
    logic [CW-1:0]   cfg_period = '0;
    logic [CW-1:0]   cfg_init = '0;
    _count_mode      cfg_mode = NO_COUNT;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [N*CW-1:0] carrier_i;
    logic [CW-1:0]   carr [N];
    logic [N*CW-1:0] period_o;
    logic [N*CW-1:0] init_carr_o;
    _count_mode      count_mode_o [N];
    _pwm_onoff       pwm_onoff_o [N];
    logic [N-1:0]    upd_done;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb [$];

    carr_update_sched #(.N_CARR(N), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_init    (cfg_init),
        .cfg_mode    (cfg_mode),
        .start       (start),
        .stop        (stop),
        .carrier_i   (carrier_i),
        .period_o    (period_o),
        .init_carr_o (init_carr_o),
        .count_mode_o(count_mode_o),
        .pwm_onoff_o (pwm_onoff_o),
        .upd_done    (upd_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        carrier_i = '0;
        for (int i = 0; i < N; i++) carrier_i[i*CW +: CW] = carr[i];
    end

    function automatic logic [CW-1:0] per(input int c);
        return period_o[c*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] ini(input int c);
        return init_carr_o[c*CW +: CW];
    endfunction

    function automatic logic [N-1:0] onv();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (pwm_onoff_o[i] == PWM_ON);
        return v;
    endfunction

    function automatic int n_nocount();
        int n = 0;
        for (int i = 0; i < N; i++) if (count_mode_o[i] == NO_COUNT) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic nxt(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_upd(input int ch, input int p, input int i,
                              input _count_mode m);
        sb.push_back('{ch, CW'(p), CW'(i), m, cyc + 1});
    endtask

    task automatic drive_wr(input int ch, input int p, input int i,
                            input _count_mode m);
        cfg_valid  = 1'b1;
        cfg_ch     = 3'(ch);
        cfg_period = CW'(p);
        cfg_init   = CW'(i);
        cfg_mode   = m;
    endtask

    task automatic idle_wr(input int ch, input int p, input int i,
                           input _count_mode m);
        drive_wr(ch, p, i, m);
        expect_upd(ch, p, i, m);
        nxt();
        cfg_valid = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (upd_done[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL upd_unexpected: ch%0d pulsed at cycle %0d, expected no pulse",
                             i, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.ch != i || per(i) != e.per || ini(i) != e.ini ||
                        count_mode_o[i] != e.md || cyc != e.at) begin
                        errors++;
                        $display("FAIL upd_xfer: got ch%0d per=%0d ini=%0d mode=%0d cyc=%0d expected ch%0d per=%0d ini=%0d mode=%0d cyc=%0d",
                                 i, per(i), ini(i), count_mode_o[i], cyc,
                                 e.ch, e.per, e.ini, e.md, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) carr[i] = '0;
        nxt(2);
        chk("rst_period", 32'(|period_o), 0);
        chk("rst_init", 32'(|init_carr_o), 0);
        chk("rst_mode", n_nocount(), N);
        chk("rst_onoff", 32'(onv()), 0);
        chk("rst_upd", 32'(upd_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        reset = 1'b0;
        nxt();

        // IDLE writes land in the active registers directly
        idle_wr(2, 100, 0, COUNT_UPDOWN);
        chk("idle_per2", 32'(per(2)), 100);
        chk("idle_mode2", 32'(count_mode_o[2]), 32'(COUNT_UPDOWN));
        idle_wr(0, 50, 5, COUNT_UP);
        idle_wr(1, 60, 0, COUNT_UP);
        idle_wr(3, 100, 0, COUNT_UP);
        idle_wr(5, 40, 0, COUNT_UP);
        chk("idle_ini0", 32'(ini(0)), 5);

        carr[0] = 57; carr[1] = 10; carr[2] = 20;
        carr[3] = 50; carr[5] = 7;

        // stop wins over start
        start = 1'b1; stop = 1'b1;
        nxt();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", 32'(busy), 0);
        chk("ss_onoff", 32'(onv()), 0);

        start = 1'b1;
        nxt();
        start = 1'b0;
        chk("start_onoff", 32'(onv()), 32'hFF);
        chk("start_busy", 32'(busy), 1);

        // RUN write waits for the zero point
        cfg_ch = 3'd0;
        chk("run_ready0", 32'(cfg_ready), 1);
        drive_wr(0, 200, 3, COUNT_UP);
        nxt();
        drive_wr(0, 999, 9, COUNT_DOWN);
        chk("pend_ready0", 32'(cfg_ready), 0);
        chk("pend_per0", 32'(per(0)), 50);
        for (int k = 0; k < 3; k++) begin
            carr[0] = CW'(58 + k);
            nxt();
            chk("wait_ready0", 32'(cfg_ready), 0);
            chk("wait_per0", 32'(per(0)), 50);
        end
        cfg_valid = 1'b0;
        carr[0] = 0;
        expect_upd(0, 200, 3, COUNT_UP);
        nxt();
        carr[0] = 1;
        chk("xfer_per0", 32'(per(0)), 200);
        chk("xfer_ready0", 32'(cfg_ready), 1);

        // write in the zero cycle defers to the next zero
        carr[2] = 0;
        drive_wr(2, 120, 0, COUNT_UPDOWN);
        nxt();
        cfg_valid = 1'b0;
        carr[2] = 5;
        chk("defer_per2", 32'(per(2)), 100);
        chk("defer_ready2", 32'(cfg_ready), 0);
        nxt(2);
        chk("defer_per2b", 32'(per(2)), 100);
        carr[2] = 0;
        expect_upd(2, 120, 0, COUNT_UPDOWN);
        nxt();
        carr[2] = 6;
        chk("defer_xfer2", 32'(per(2)), 120);

        // carrier equal to period on ch3
        drive_wr(3, 80, 0, COUNT_UP);
        nxt();
        cfg_valid = 1'b0;
        carr[3] = 100;
`ifdef CARR_UPD_PEAK_EN
        expect_upd(3, 80, 0, COUNT_UP);
        nxt();
        carr[3] = 10;
        chk("peak_per3", 32'(per(3)), 80);
`else
        nxt();
        carr[3] = 0;
        chk("nopeak_per3", 32'(per(3)), 100);
        chk("nopeak_ready3", 32'(cfg_ready), 0);
        expect_upd(3, 80, 0, COUNT_UP);
        nxt();
        carr[3] = 10;
        chk("zero_per3", 32'(per(3)), 80);
`endif

        // ch1 left pending across the drain
        carr[1] = 30;
        drive_wr(1, 90, 0, COUNT_UP);
        nxt();
        cfg_valid = 1'b0;
        chk("pend_ready1", 32'(cfg_ready), 0);

        carr[0] = 0; carr[2] = 0; carr[3] = 0; carr[5] = 0;
        stop = 1'b1;
        nxt();
        stop = 1'b0;
        chk("drain_busy", 32'(busy), 1);
        chk("drain_on", 32'(onv()), 32'hFF);
        cfg_ch = 3'd4;
        chk("drain_ready", 32'(cfg_ready), 0);
        start = 1'b1;
        nxt();
        start = 1'b0;
        chk("drain_off1", 32'(onv()), 32'h02);
        chk("drain_busy2", 32'(busy), 1);
        nxt();
        chk("drain_hold1", 32'(onv()), 32'h02);
        carr[1] = 0;
        nxt();
        carr[1] = 12;
        chk("drain_alloff", 32'(onv()), 0);
        chk("drain_busy3", 32'(busy), 1);
        nxt();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_per1", 32'(per(1)), 60);
        chk("idle_ready", 32'(cfg_ready), 1);

        start = 1'b1;
        nxt();
        start = 1'b0;
        cfg_ch = 3'd1;
        chk("rerun_ready1", 32'(cfg_ready), 1);
        chk("rerun_busy", 32'(busy), 1);

        // reset mid-RUN with ch5 pending
        carr[5] = 7;
        drive_wr(5, 77, 0, COUNT_UP);
        nxt();
        cfg_valid = 1'b0;
        chk("pend_ready5", 32'(cfg_ready), 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_period", 32'(|period_o), 0);
        chk("arst_init", 32'(|init_carr_o), 0);
        chk("arst_mode", n_nocount(), N);
        chk("arst_onoff", 32'(onv()), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_upd", 32'(upd_done), 0);
        nxt(2);
        reset = 1'b0;
        carr[5] = 0;
        nxt(4);
        chk("post_per5", 32'(per(5)), 0);
        cfg_ch = 3'd5;
        chk("post_ready5", 32'(cfg_ready), 1);
        chk("post_busy", 32'(busy), 0);

        nxt(2);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
